// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command framer and its serial CRC7 stage.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        STOP = 3'd4
    } state_e;

    localparam int         CMD_FRAME_BITS   = 48;
    localparam int         CMD_PAYLOAD_BITS = 40;
    localparam logic [6:0] CRC7_POLY        = 7'h09;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Command request and serial line bundle between the host logic and sd_cmd_framer.
interface sd_cmd_framer_if;

    // A command is taken on a rising edge where CMD_VALID and CMD_READY are both 1;
    // CMD_INDEX/CMD_ARG are sampled only at that edge and may change freely otherwise.
    logic        BIT_EN;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [5:0]  CMD_INDEX;
    logic [31:0] CMD_ARG;
    logic        CMD_OUT;
    logic        CMD_OE;
    logic        BUSY;
    logic        DONE;

    modport master (
        output BIT_EN, CMD_VALID, CMD_INDEX, CMD_ARG,
        input  CMD_READY, CMD_OUT, CMD_OE, BUSY, DONE
    );

    modport slave (
        input  BIT_EN, CMD_VALID, CMD_INDEX, CMD_ARG,
        output CMD_READY, CMD_OUT, CMD_OE, BUSY, DONE
    );

endinterface

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 generator: one bit per enabled cycle, synchronous clear has priority.
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 7'h00;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_framer.sv
// SD command-line transmitter: start/tx bits, index, argument, CRC7, end bit, MSB first.
// Optional idle-high preamble before the start bit is enabled by SD_CMD_PREAMBLE_EN.
module sd_cmd_framer
    import sd_cmd_pkg::*;
#(
    parameter int NCC_CYCLES = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    sd_cmd_framer_if.slave     bus,
    output state_e             dbg_state_o
);

    state_e                      state_q, state_d;
    logic [CMD_PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [5:0]                  cnt_q, cnt_d;
    logic                        ready_q;
    logic                        done_q;
    logic                        crc_clr;
    logic                        crc_en;
    logic [6:0]                  crc;
    logic [2:0]                  crc_sel;
    logic                        accept;

`ifdef SD_CMD_PREAMBLE_EN
    localparam int             PRE_W    = (NCC_CYCLES > 0) ? $clog2(NCC_CYCLES + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(NCC_CYCLES - 1);
    logic [PRE_W-1:0]            pre_q, pre_d;
`else
    logic                        unused_ncc;
    assign unused_ncc = (NCC_CYCLES != 0);
`endif

    assign accept = bus.CMD_VALID & ready_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
`ifdef SD_CMD_PREAMBLE_EN
        pre_d   = pre_q;
`endif
        case (state_q)
            IDLE: begin
                // BIT_EN is deliberately not looked at here: the accept cycle never consumes a strobe.
                if (accept) begin
                    shift_d = {1'b0, 1'b1, bus.CMD_INDEX, bus.CMD_ARG};
                    cnt_d   = 6'd0;
                    crc_clr = 1'b1;
`ifdef SD_CMD_PREAMBLE_EN
                    pre_d   = '0;
                    state_d = (NCC_CYCLES == 0) ? DATA : PRE;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef SD_CMD_PREAMBLE_EN
            PRE: begin
                if (bus.BIT_EN) begin
                    pre_d = pre_q + 1'b1;
                    if (pre_q == PRE_LAST) begin
                        state_d = DATA;
                    end
                end
            end
`endif
            DATA: begin
                if (bus.BIT_EN) begin
                    crc_en  = 1'b1;
                    shift_d = {shift_q[CMD_PAYLOAD_BITS-2:0], 1'b0};
                    if (cnt_q == 6'(CMD_PAYLOAD_BITS - 1)) begin
                        cnt_d   = 6'd0;
                        state_d = CRC;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            CRC: begin
                if (bus.BIT_EN) begin
                    if (cnt_q == 6'd6) begin
                        cnt_d   = 6'd0;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            STOP: begin
                if (bus.BIT_EN) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= 6'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SD_CMD_PREAMBLE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            // Ready tracks the next state so it rises together with DONE, allowing back-to-back frames.
            ready_q <= (state_d == IDLE);
            done_q  <= (state_q == STOP) && bus.BIT_EN;
`ifdef SD_CMD_PREAMBLE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    sd_crc7_serial u_crc (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (shift_q[CMD_PAYLOAD_BITS-1]),
        .crc_o  (crc)
    );

    assign crc_sel = 3'd6 - cnt_q[2:0];

    always_comb begin
        bus.CMD_OUT = 1'b1;
        case (state_q)
            DATA:    bus.CMD_OUT = shift_q[CMD_PAYLOAD_BITS-1];
            CRC:     bus.CMD_OUT = crc[crc_sel];
            default: bus.CMD_OUT = 1'b1;
        endcase
    end

    assign bus.CMD_OE    = (state_q != IDLE);
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.CMD_READY = ready_q;
    assign bus.DONE      = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer; frame expectations follow SD_CMD_PREAMBLE_EN if defined.
module tb_sd_cmd_framer;
    import sd_cmd_pkg::*;

    logic   CLK   = 1'b0;
    logic   RST_N = 1'b1;
    state_e dbg_state;

    sd_cmd_framer_if bus();

    sd_cmd_framer #(.NCC_CYCLES(8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

`ifdef SD_CMD_PREAMBLE_EN
    localparam int   NBITS     = 56;
    localparam logic FIRST_BIT = 1'b1;
`else
    localparam int   NBITS     = 48;
    localparam logic FIRST_BIT = 1'b0;
`endif

    function automatic logic [63:0] frame_of(input logic [47:0] f);
`ifdef SD_CMD_PREAMBLE_EN
        return {8'h00, 8'hFF, f};
`else
        return {16'h0000, f};
`endif
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    // Bit-time strobe generator: every en_period-th cycle.
    int en_period = 1;
    int en_ph     = 0;
    always @(posedge CLK) begin
        #1;
        en_ph      = (en_ph + 1) % en_period;
        bus.BIT_EN = (en_ph == 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] cap_frame;
    int          cap_bits;
    int          cap_viol;
    int          cap_rdy_busy;
    logic        cap_timeout;
    logic        toggle_inputs = 1'b0;

    // Handshake; returns at the negedge of the first frame-bit cycle.
    task automatic do_accept(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input logic hold_valid);
        @(posedge CLK); #1;
        bus.CMD_VALID = 1'b1;
        bus.CMD_INDEX = idx;
        bus.CMD_ARG   = arg;
        @(negedge CLK);
        check({tag, "_ready_idle"}, 64'(bus.CMD_READY), 64'd1);
        @(posedge CLK); #1;
        if (!hold_valid) bus.CMD_VALID = 1'b0;
        @(negedge CLK);
        check({tag, "_first_oe"},   64'(bus.CMD_OE),    64'd1);
        check({tag, "_first_bit"},  64'(bus.CMD_OUT),   64'(FIRST_BIT));
        check({tag, "_busy"},       64'(bus.BUSY),      64'd1);
        check({tag, "_ready_busy"}, 64'(bus.CMD_READY), 64'd0);
    endtask

    // Collects one bit per strobe while CMD_OE=1; starts at the current negedge, stops at DONE.
    task automatic capture(input int budget);
        logic prev_out, prev_en, prev_oe;
        cap_frame    = '0;
        cap_bits     = 0;
        cap_viol     = 0;
        cap_rdy_busy = 0;
        cap_timeout  = 1'b1;
        prev_out     = 1'b1;
        prev_en      = 1'b1;
        prev_oe      = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge CLK);
            if (bus.DONE) begin
                cap_timeout = 1'b0;
                if (toggle_inputs) bus.CMD_VALID = 1'b0;
                break;
            end
            if (bus.CMD_OE && prev_oe && !prev_en && (bus.CMD_OUT !== prev_out)) cap_viol++;
            if (bus.CMD_OE && bus.BIT_EN) begin
                cap_frame = {cap_frame[62:0], bus.CMD_OUT};
                cap_bits++;
            end
            if (bus.BUSY && bus.CMD_READY) cap_rdy_busy++;
            if (toggle_inputs) begin
                bus.CMD_VALID = 1'($urandom_range(0, 1));
                bus.CMD_INDEX = 6'($urandom_range(0, 63));
                bus.CMD_ARG   = $urandom;
            end
            prev_out = bus.CMD_OUT;
            prev_en  = bus.BIT_EN;
            prev_oe  = bus.CMD_OE;
        end
    endtask

    task automatic frame_checks(input string tag, input logic [63:0] exp);
        check({tag, "_done_seen"}, 64'(cap_timeout), 64'd0);
        check({tag, "_frame"},     cap_frame,        exp);
        check({tag, "_nbits"},     64'(cap_bits),    64'(NBITS));
        check({tag, "_hold"},      64'(cap_viol),    64'd0);
    endtask

    task automatic idle_checks(input string tag);
        @(negedge CLK);
        check({tag, "_done_1cyc"}, 64'(bus.DONE),      64'd0);
        check({tag, "_oe_off"},    64'(bus.CMD_OE),    64'd0);
        check({tag, "_out_idle"},  64'(bus.CMD_OUT),   64'd1);
        check({tag, "_ready_end"}, 64'(bus.CMD_READY), 64'd1);
    endtask

    initial begin
        int got;
        bus.CMD_VALID = 1'b0;
        bus.CMD_INDEX = '0;
        bus.CMD_ARG   = '0;

        // Reset values
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_out",   64'(bus.CMD_OUT),   64'd1);
        check("rst_oe",    64'(bus.CMD_OE),    64'd0);
        check("rst_ready", 64'(bus.CMD_READY), 64'd0);
        check("rst_busy",  64'(bus.BUSY),      64'd0);
        check("rst_done",  64'(bus.DONE),      64'd0);
        check("rst_state", 64'(dbg_state),     64'(IDLE));
        @(posedge CLK); #2 RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_ready", 64'(bus.CMD_READY), 64'd1);

        for (int p = 1; p <= 4; p += 3) begin
            en_period = p;

            do_accept("cmd0", 6'd0, 32'h0000_0000, 1'b0);
            capture(2000);
            frame_checks("cmd0", frame_of(48'h40_0000_0000_95));
            idle_checks("cmd0");

            do_accept("cmd17", 6'd17, 32'h0000_0000, 1'b0);
            capture(2000);
            frame_checks("cmd17", frame_of(48'h51_0000_0000_55));
            idle_checks("cmd17");

            // CMD8 with CMD_VALID left high and CMD0 staged for a back-to-back accept
            do_accept("cmd8", 6'd8, 32'h0000_01AA, 1'b1);
            bus.CMD_INDEX = 6'd0;
            bus.CMD_ARG   = 32'h0;
            capture(2000);
            frame_checks("cmd8", frame_of(48'h48_0000_01AA_87));
            check("b2b_ready_at_done", 64'(bus.CMD_READY), 64'd1);
            @(negedge CLK);
            check("b2b_oe",    64'(bus.CMD_OE),  64'd1);
            check("b2b_busy",  64'(bus.BUSY),    64'd1);
            check("b2b_first", 64'(bus.CMD_OUT), 64'(FIRST_BIT));
            check("b2b_done",  64'(bus.DONE),    64'd0);
            bus.CMD_VALID = 1'b0;
            capture(2000);
            frame_checks("b2b_cmd0", frame_of(48'h40_0000_0000_95));
            idle_checks("b2b_cmd0");
        end

        // Asynchronous reset mid-frame
        en_period = 1;
        do_accept("abort", 6'd8, 32'h0000_01AA, 1'b0);
        got = 0;
        for (int c = 0; c < 500 && got < 20; c++) begin
            if (c > 0) @(negedge CLK);
            if (bus.CMD_OE && bus.BIT_EN) got++;
        end
        check("abort_reach", 64'(got), 64'd20);
        #2 RST_N = 1'b0;
        #1;
        check("abort_oe",    64'(bus.CMD_OE),    64'd0);
        check("abort_out",   64'(bus.CMD_OUT),   64'd1);
        check("abort_busy",  64'(bus.BUSY),      64'd0);
        check("abort_ready", 64'(bus.CMD_READY), 64'd0);
        check("abort_done",  64'(bus.DONE),      64'd0);
        @(posedge CLK); #1;
        check("abort_done_hold", 64'(bus.DONE), 64'd0);
        @(negedge CLK); RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("abort_ready_back", 64'(bus.CMD_READY), 64'd1);
        check("abort_no_done",    64'(bus.DONE),      64'd0);
        do_accept("post_abort", 6'd0, 32'h0000_0000, 1'b0);
        capture(2000);
        frame_checks("post_abort", frame_of(48'h40_0000_0000_95));
        idle_checks("post_abort");

        // Inputs churn while busy; the frame must not change
        en_period = 4;
        do_accept("toggle", 6'd17, 32'h0000_0000, 1'b0);
        toggle_inputs = 1'b1;
        capture(2000);
        toggle_inputs = 1'b0;
        check("toggle_ready_low", 64'(cap_rdy_busy), 64'd0);
        frame_checks("toggle", frame_of(48'h51_0000_0000_55));
        idle_checks("toggle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
Host-side SD command-line transmitter that sits directly upstream of the serial CRC7 stage.
- Accepts a 6-bit command index and 32-bit argument over a valid/ready handshake.
- Serializes the 48-bit SD command frame MSB-first: start bit 0, transmission bit 1, index, argument, CRC7, end bit 1.
- Feeds each header/payload bit to an embedded serial CRC7 generator and appends the resulting 7-bit CRC to the frame.

Parameters:
- NCC_CYCLES, 8: idle-high preamble bit-times sent before the start bit; used only when SD_CMD_PREAMBLE_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- BIT_EN  input  1  bit-time strobe; the frame advances one bit only in cycles where BIT_EN=1.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  block can accept a command.
- CMD_INDEX  input  6  command index, captured on handshake.
- CMD_ARG  input  32  argument, captured on handshake.
- CMD_OUT  output  1  serial command bit.
- CMD_OE  output  1  line drive enable.
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle pulse after the end bit completes.

Behaviour:
- Reset (async, RST_N=0), all outputs: CMD_OUT=1, CMD_OE=0, CMD_READY=0, BUSY=0, DONE=0; state=IDLE; shift register, bit counter and CRC register cleared.
- CMD_READY=1 in IDLE only, from the first cycle after reset release.
- Handshake: accepted when CMD_VALID & CMD_READY at a rising edge. Shift register loads {1'b0, 1'b1, CMD_INDEX, CMD_ARG}. CMD_READY drops and BUSY rises the next cycle.
- States: IDLE -> (PRE) -> DATA -> CRC -> STOP -> IDLE.
  - IDLE -> PRE on accept (macro defined); IDLE -> DATA on accept (macro undefined).
  - PRE: CMD_OE=1, CMD_OUT=1 for NCC_CYCLES BIT_EN strobes, then DATA.
  - DATA: 40 bit-times. CMD_OUT = shift MSB. On each BIT_EN the CRC updates with that bit and the register shifts left.
  - CRC: 7 bit-times, CRC register MSB first (crc[6] down to crc[0]).
  - STOP: one bit-time of CMD_OUT=1.
- Timing:
  - First frame bit appears on CMD_OUT/CMD_OE the cycle after accept.
  - Each bit is held until the next BIT_EN strobe, which advances to the following bit.
  - BIT_EN in the accept cycle is ignored.
- CRC7: polynomial x^7+x^3+1, init 0.
  - Per bit: fb = crc[6]^bit; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
  - Covers exactly the 40 DATA bits.
- Completion: on the BIT_EN that ends STOP, go to IDLE, CMD_OE=0, CMD_OUT=1, BUSY=0, DONE=1 for one cycle. CMD_READY=1 in that same cycle, so a back-to-back accept is allowed.
- Held BIT_EN=0 freezes all state; outputs stay stable.
- CMD_VALID and CMD_INDEX/CMD_ARG are ignored while BUSY; inputs are captured only at accept.
- RST_N asserted mid-frame: immediate abort to reset values, no DONE pulse.
- Counter widths: 6-bit bit counter. The preamble counter is sized $clog2(NCC_CYCLES+1); NCC_CYCLES=0 skips PRE.

Optional Feature:
- Macro: SD_CMD_PREAMBLE_EN.
- Defined: PRE state present, driving NCC_CYCLES bit-times of OE=1/OUT=1 before the start bit. Frame length is NCC_CYCLES+48 strobes.
- Undefined: no PRE state or preamble counter; NCC_CYCLES is unused. Frame length is 48 strobes.

Decomposition:
- Package sd_cmd_pkg:
  - State enum (IDLE, PRE, DATA, CRC, STOP).
  - CMD_FRAME_BITS=48, CMD_PAYLOAD_BITS=40, CRC7_POLY=7'h09.
- One sub-module: sd_crc7_serial (bit, enable, clear, 7-bit crc), instantiated in the framer with the same update rule as the standalone CRC7 stage.

Test Plan:
- Run each scenario with BIT_EN=1 constantly and again with BIT_EN every 4th cycle.
- CMD0, arg 0x00000000 -> CMD_OUT sequence 0x40_00000000_95 over 48 strobes; DONE pulses once; CMD_OE deasserts after the end bit.
- CMD17, arg 0x00000000 -> frame 0x51_00000000_55; with BIT_EN every 4th cycle each bit is held 4 cycles.
- CMD8, arg 0x000001AA -> frame 0x48_000001AA_87; then a new CMD_VALID held high, CMD0 arg 0 -> second frame starts the cycle after DONE, no idle bit-time.
- RST_N pulsed low at bit 20 of a CMD8 frame -> CMD_OE=0 and CMD_OUT=1 asynchronously, no DONE. Next CMD0 frame is 0x40_00000000_95, confirming CRC cleared.
- With SD_CMD_PREAMBLE_EN, NCC_CYCLES=8, CMD0 -> 8 high bits with CMD_OE=1, then 0x40_00000000_95; 56 strobes total.
- Toggle CMD_INDEX/CMD_ARG while BUSY -> transmitted frame unchanged; CMD_READY=0 throughout.
